// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle step sequencer:
// FSM states, opcode classes and the step codes fed to the dec16 timing decoder.
package mc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [3:0] T_FETCH  = 4'd0;
    localparam logic [3:0] T_DECODE = 4'd1;
    localparam logic [3:0] T_EXEC   = 4'd2;
    localparam logic [3:0] T_MEM    = 4'd3;
    localparam logic [3:0] T_WB_ALU = 4'd3;
    localparam logic [3:0] T_WB_LD  = 4'd4;

    function automatic logic is_alu(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd7);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'hB) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter; expires once WAIT_MAX wait cycles have elapsed.
module mc_wait_timer
    import mc_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_MAX);

    logic [WAIT_W-1:0] r_waitCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waitCnt <= '0;
        end else if (i_clear) begin
            r_waitCnt <= '0;
        end else if (i_inc && !o_expired) begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end
    end

    assign o_expired = (r_waitCnt >= LIMIT);

endmodule

// File: rtl/mc_step_sequencer.sv
// Multicycle control sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// emits the datapath strobes and the registered step code for the dec16 timing decoder.
module mc_step_sequencer
    import mc_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       halt_req,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    output logic [3:0] step,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       alu_go,
    output logic       reg_we,
    output logic       busy,
    output logic       done,
    output logic       illegal,
    output logic       timeout
);

    state_t     r_state;
    logic [3:0] r_step;
    logic [3:0] r_opQ;
    logic       r_busy;
    logic       r_done;
    logic       r_illegal;
    logic       r_timeout;

    state_t     w_next;
    state_t     w_endNext;
    logic [3:0] w_stepNext;
    logic       w_setIllegal;
    logic       w_setTimeout;
    logic       w_clrFlags;
    logic       w_waitInc;
    logic       w_waitClr;
    logic       w_expired;

    assign w_waitInc = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
    assign w_waitClr = (w_next != r_state);

    mc_wait_timer #(
        .WAIT_MAX (WAIT_MAX),
        .WAIT_W   (WAIT_W)
    ) u_waitTimer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_waitClr),
        .i_inc     (w_waitInc),
        .o_expired (w_expired)
    );

    // END is not a cycle of its own: the last step of an instruction jumps straight on.
    always_comb begin
        w_endNext    = halt_req ? S_HALTED : S_FETCH;
        w_next       = r_state;
        w_setIllegal = 1'b0;
        w_setTimeout = 1'b0;
        w_clrFlags   = 1'b0;
        case (r_state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    w_next     = S_FETCH;
                    w_clrFlags = 1'b1;
                end
            end
            S_FETCH: begin
                if (mem_ready) begin
                    w_next = S_DECODE;
                end else if (w_expired) begin
                    w_next       = S_HALTED;
                    w_setTimeout = 1'b1;
                end
            end
            S_DECODE: begin
                if (opcode == OP_NOP) begin
                    w_next = w_endNext;
                end else if (opcode == OP_HALT) begin
                    w_next = S_HALTED;
                end else if (is_illegal(opcode)) begin
                    w_next       = S_HALTED;
                    w_setIllegal = 1'b1;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_alu(r_opQ)) begin
                    w_next = S_WB;
                end else if ((r_opQ == OP_LOAD) || (r_opQ == OP_STORE)) begin
                    w_next = S_MEM;
                end else begin
                    w_next = w_endNext;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    w_next = (r_opQ == OP_LOAD) ? S_WB : w_endNext;
                end else if (w_expired) begin
                    w_next       = S_HALTED;
                    w_setTimeout = 1'b1;
                end
            end
            S_WB: begin
                w_next = w_endNext;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // The step code is a pure function of where the instruction lands next.
    always_comb begin
        case (w_next)
            S_DECODE: w_stepNext = T_DECODE;
            S_EXEC:   w_stepNext = T_EXEC;
            S_MEM:    w_stepNext = T_MEM;
            S_WB:     w_stepNext = (r_opQ == OP_LOAD) ? T_WB_LD : T_WB_ALU;
            default:  w_stepNext = T_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_step    <= T_FETCH;
            r_opQ     <= OP_NOP;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            r_step  <= w_stepNext;
            r_busy  <= (w_next != S_IDLE) && (w_next != S_HALTED);
            r_done  <= (w_next == S_HALTED);
            if (r_state == S_DECODE) begin
                r_opQ <= opcode;
            end
            if (w_clrFlags) begin
                r_illegal <= 1'b0;
                r_timeout <= 1'b0;
            end
            if (w_setIllegal) begin
                r_illegal <= 1'b1;
            end
            if (w_setTimeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign step    = r_step;
    assign busy    = r_busy;
    assign done    = r_done;
    assign illegal = r_illegal;
    assign timeout = r_timeout;

    assign mem_req = (r_state == S_FETCH) || (r_state == S_MEM);
    assign mem_we  = (r_state == S_MEM) && (r_opQ == OP_STORE);
    assign ir_load = (r_state == S_FETCH) && mem_ready;
    assign pc_inc  = (r_state == S_DECODE);
    assign alu_go  = (r_state == S_EXEC);
    assign pc_load = (r_state == S_EXEC) && (r_opQ == OP_JMP);
    assign reg_we  = (r_state == S_WB);

endmodule

// File: tb/tb_mc_step_sequencer.sv
// Self-checking bench for mc_step_sequencer: directed literal sequences plus randomized
// stimulus compared every cycle against an instruction-position reference model.
module tb_mc_step_sequencer;

    localparam int WAIT_MAX = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       halt_req;
    logic [3:0] opcode;
    logic       mem_ready;
    logic [3:0] step;
    logic       mem_req, mem_we, ir_load, pc_inc, pc_load, alu_go, reg_we;
    logic       busy, done, illegal, timeout;

    int testsRun    = 0;
    int testsFailed = 0;

    mc_step_sequencer #(
        .WAIT_MAX (WAIT_MAX),
        .WAIT_W   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .halt_req  (halt_req),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .step      (step),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .ir_load   (ir_load),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .alu_go    (alu_go),
        .reg_we    (reg_we),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 running, 2 halted; mPos is the cycle position
    // inside the current instruction, which is also the step code the decoder sees.
    int         mMode = 0;
    int         mPos  = 0;
    int         mWait = 0;
    logic [3:0] mOp   = 4'h0;
    logic       mIll  = 1'b0;
    logic       mTo   = 1'b0;

    function automatic int instrLen(input logic [3:0] op);
        if (op == 4'h0) return 2;
        if (op >= 4'h1 && op <= 4'h7) return 4;
        if (op == 4'h8) return 5;
        if (op == 4'h9) return 4;
        if (op == 4'hA) return 3;
        return 2;
    endfunction

    function automatic bit inMemPhase();
        return (mMode == 1) && ((mPos == 0) || (mPos == 3 && (mOp == 4'h8 || mOp == 4'h9)));
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mMode = 0; mPos = 0; mWait = 0; mOp = 4'h0; mIll = 1'b0; mTo = 1'b0;
        end else if (mMode != 1) begin
            if (start) begin
                mMode = 1; mPos = 0; mWait = 0; mIll = 1'b0; mTo = 1'b0;
            end
        end else if (inMemPhase() && !mem_ready) begin
            if (mWait == WAIT_MAX) begin
                mTo = 1'b1; mMode = 2; mPos = 0; mWait = 0;
            end else begin
                mWait++;
            end
        end else begin
            mWait = 0;
            if (mPos == 1) mOp = opcode;
            if (mPos == 1 && mOp == 4'hF) begin
                mMode = 2; mPos = 0;
            end else if (mPos == 1 && mOp >= 4'hB && mOp <= 4'hE) begin
                mIll = 1'b1; mMode = 2; mPos = 0;
            end else if (mPos + 1 == instrLen(mOp)) begin
                if (halt_req) mMode = 2;
                mPos = 0;
            end else begin
                mPos++;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0]  eStep;
        logic [10:0] eVec;
        logic [10:0] aVec;
        bit          run;
        run = (mMode == 1);
        if (!rst_n) begin
            eStep = 4'd0;
            eVec  = '0;
        end else begin
            eStep = run ? 4'(mPos) : 4'd0;
            eVec  = {run, mMode == 2, mIll, mTo, inMemPhase(),
                     run && mPos == 3 && mOp == 4'h9,
                     run && mPos == 0 && mem_ready,
                     run && mPos == 1,
                     run && mPos == 2 && mOp == 4'hA,
                     run && mPos == 2,
                     run && ((mPos == 3 && mOp >= 4'h1 && mOp <= 4'h7) || (mPos == 4 && mOp == 4'h8))};
        end
        aVec = {busy, done, illegal, timeout, mem_req, mem_we, ir_load, pc_inc, pc_load, alu_go, reg_we};
        testsRun++;
        if (step !== eStep || aVec !== eVec) begin
            testsFailed++;
            $display("[TB] FAIL model_cycle t=%0t: step=%0d vec=%b, expected step=%0d vec=%b",
                     $time, step, aVec, eStep, eVec);
        end
    end

    task automatic applyStimulus(input logic s, input logic h, input logic [3:0] op, input logic r);
        @(posedge clk);
        #1;
        start     = s;
        halt_req  = h;
        opcode    = op;
        mem_ready = r;
        @(negedge clk);
    endtask

    // Vector layout: {busy,done,illegal,timeout}_{mem_req,mem_we,ir_load,pc_inc,pc_load,alu_go,reg_we}
    task automatic checkOutput(input string name, input logic [3:0] expStep, input logic [10:0] expVec);
        logic [10:0] act;
        act = {busy, done, illegal, timeout, mem_req, mem_we, ir_load, pc_inc, pc_load, alu_go, reg_we};
        testsRun++;
        if (step !== expStep || act !== expVec) begin
            testsFailed++;
            $display("[TB] FAIL %s: step=%0d vec=%b, expected step=%0d vec=%b",
                     name, step, act, expStep, expVec);
        end
    endtask

    // Reset lands mid-cycle so the strobes must drop without waiting for a clock edge.
    task automatic resetPulse(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput(name, 4'd0, 11'b0000_0000000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int readyPct;
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; opcode = 4'h0; mem_ready = 1'b0;
        @(negedge clk);
        checkOutput("reset_state", 4'd0, 11'b0000_0000000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("after_release", 4'd0, 11'b0000_0000000);

        applyStimulus(1, 0, 4'h3, 1); checkOutput("alu_idle_start", 0, 11'b0000_0000000);
        applyStimulus(0, 0, 4'h3, 1); checkOutput("alu_fetch",      0, 11'b1000_1010000);
        applyStimulus(0, 0, 4'h3, 1); checkOutput("alu_decode",     1, 11'b1000_0001000);
        applyStimulus(0, 0, 4'h3, 1); checkOutput("alu_exec",       2, 11'b1000_0000010);
        applyStimulus(0, 0, 4'h3, 1); checkOutput("alu_wb",         3, 11'b1000_0000001);
        applyStimulus(0, 0, 4'h8, 1); checkOutput("ld_fetch",       0, 11'b1000_1010000);
        applyStimulus(0, 0, 4'h8, 1); checkOutput("ld_decode",      1, 11'b1000_0001000);
        applyStimulus(0, 0, 4'h8, 1); checkOutput("ld_exec",        2, 11'b1000_0000010);
        applyStimulus(0, 0, 4'h8, 0); checkOutput("ld_mem_wait1",   3, 11'b1000_1000000);
        applyStimulus(0, 0, 4'h8, 0); checkOutput("ld_mem_wait2",   3, 11'b1000_1000000);
        applyStimulus(0, 0, 4'h8, 1); checkOutput("ld_mem_ready",   3, 11'b1000_1000000);
        applyStimulus(0, 0, 4'h9, 1); checkOutput("ld_wb",          4, 11'b1000_0000001);
        applyStimulus(0, 0, 4'h9, 1); checkOutput("st_fetch",       0, 11'b1000_1010000);
        applyStimulus(0, 0, 4'h9, 1); checkOutput("st_decode",      1, 11'b1000_0001000);
        applyStimulus(0, 0, 4'h9, 1); checkOutput("st_exec",        2, 11'b1000_0000010);
        applyStimulus(0, 1, 4'h9, 1); checkOutput("st_mem",         3, 11'b1000_1100000);
        applyStimulus(0, 0, 4'h9, 1); checkOutput("st_halted",      0, 11'b0100_0000000);
        applyStimulus(1, 0, 4'hC, 1); checkOutput("halted_start",   0, 11'b0100_0000000);
        applyStimulus(0, 0, 4'hC, 1); checkOutput("ill_fetch",      0, 11'b1000_1010000);
        applyStimulus(0, 0, 4'hC, 1); checkOutput("ill_decode",     1, 11'b1000_0001000);
        applyStimulus(0, 0, 4'h0, 0); checkOutput("ill_halted",     0, 11'b0110_0000000);
        applyStimulus(1, 0, 4'h0, 0); checkOutput("ill_start",      0, 11'b0110_0000000);
        applyStimulus(0, 0, 4'h0, 0); checkOutput("to_wait1",       0, 11'b1000_1000000);
        applyStimulus(0, 0, 4'h0, 0); checkOutput("to_wait2",       0, 11'b1000_1000000);
        applyStimulus(0, 0, 4'h0, 0); checkOutput("to_wait3",       0, 11'b1000_1000000);
        applyStimulus(0, 0, 4'h0, 0); checkOutput("to_expire",      0, 11'b1000_1000000);
        applyStimulus(0, 0, 4'h0, 0); checkOutput("to_halted",      0, 11'b0101_0000000);
        applyStimulus(1, 0, 4'h0, 0); checkOutput("to_start",       0, 11'b0101_0000000);
        applyStimulus(0, 0, 4'h0, 0); checkOutput("edge_wait1",     0, 11'b1000_1000000);
        applyStimulus(0, 0, 4'h0, 0); checkOutput("edge_wait2",     0, 11'b1000_1000000);
        applyStimulus(0, 0, 4'h0, 0); checkOutput("edge_wait3",     0, 11'b1000_1000000);
        applyStimulus(0, 0, 4'h0, 1); checkOutput("edge_ready",     0, 11'b1000_1010000);
        applyStimulus(0, 0, 4'h0, 1); checkOutput("edge_nop",       1, 11'b1000_0001000);
        applyStimulus(0, 0, 4'h8, 1); checkOutput("rst_fetch",      0, 11'b1000_1010000);
        applyStimulus(0, 0, 4'h8, 1); checkOutput("rst_decode",     1, 11'b1000_0001000);
        applyStimulus(0, 0, 4'h8, 1); checkOutput("rst_exec",       2, 11'b1000_0000010);
        applyStimulus(0, 0, 4'h8, 0); checkOutput("rst_mem_wait",   3, 11'b1000_1000000);
        resetPulse("rst_mid_mem");
        applyStimulus(1, 0, 4'hA, 1); checkOutput("restart_idle",   0, 11'b0000_0000000);
        applyStimulus(0, 0, 4'hA, 1); checkOutput("jmp_fetch",      0, 11'b1000_1010000);
        applyStimulus(0, 0, 4'hA, 1); checkOutput("jmp_decode",     1, 11'b1000_0001000);
        applyStimulus(0, 0, 4'hA, 1); checkOutput("jmp_exec",       2, 11'b1000_0000110);
        applyStimulus(0, 0, 4'h0, 1); checkOutput("jmp_next_fetch", 0, 11'b1000_1010000);

        readyPct = 80;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) readyPct = ($urandom % 2 == 0) ? 80 : 30;
            applyStimulus(($urandom % 4) == 0, ($urandom % 8) == 0,
                          4'($urandom % 16), ($urandom % 100) < readyPct);
            if ($urandom % 300 == 0) resetPulse("rand_async_reset");
        end

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mc_step_sequencer.md
Name: mc_step_sequencer

Overview:
- Multicycle control sequencer for the processor core.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the 4-bit step code into the registered 4-to-16 timing decoder (dec16).
- Emits the per-step datapath control strobes, handles memory wait states with a timeout, and stops on HALT, illegal opcode or external halt request.

Parameters:
- WAIT_MAX, 15, max cycles FETCH or MEM may wait for mem_ready before timeout (1..255).
- WAIT_W, 8, width of the internal wait counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; starts or restarts execution from IDLE/HALTED.
- halt_req  input  1  level; sampled at end of each instruction.
- opcode  input  4  IR[15:12], valid from DECODE onward.
- mem_ready  input  1  memory handshake complete this cycle.
- step  output  4  registered step code to dec16 i1..i4 (i1 = MSB).
- mem_req  output  1  memory request.
- mem_we  output  1  memory write (STORE only).
- ir_load  output  1  load IR.
- pc_inc  output  1  PC += 1.
- pc_load  output  1  PC <= target (JMP).
- alu_go  output  1  ALU operate / address compute.
- reg_we  output  1  register file write.
- busy  output  1  registered; 1 in any state except IDLE/HALTED.
- done  output  1  registered; 1 in HALTED.
- illegal  output  1  registered sticky flag: illegal opcode.
- timeout  output  1  registered sticky flag: mem wait exceeded.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, step=0, op_q=0, wait_cnt=0, busy=0, done=0, illegal=0, timeout=0. All strobes are 0 while in reset.
- Strobes are combinational from state, op_q and mem_ready. step, busy, done and the flags are registered.
- The dec16 output lags step by one cycle, so consumers of the timing vector see step N one cycle later.
- Opcode classes:
  - 0000 NOP.
  - 0001-0111 ALU.
  - 1000 LOAD.
  - 1001 STORE.
  - 1010 JMP.
  - 1111 HALT.
  - 1011-1110 illegal.
- IDLE: step=0. start=1 -> FETCH; clears illegal and timeout.
- FETCH (step 0): mem_req=1.
  - mem_ready=1: ir_load=1 in the same cycle -> DECODE.
  - Otherwise wait_cnt++. When wait_cnt reaches WAIT_MAX with no mem_ready: timeout<=1 -> HALTED.
- DECODE (step 1): pc_inc=1; op_q<=opcode.
  - NOP -> END.
  - HALT -> HALTED.
  - Illegal -> HALTED with illegal<=1.
  - All others -> EXEC.
- EXEC (step 2): alu_go=1; pc_load=1 if JMP.
  - ALU -> WB.
  - LOAD or STORE -> MEM.
  - JMP -> END.
- MEM (step 3): mem_req=1; mem_we=1 for STORE. Same wait and timeout rule as FETCH.
  - On mem_ready: LOAD -> WB; STORE -> END.
- WB (step 3 for ALU, step 4 for LOAD): reg_we=1 -> END.
- END: a transition point, not a cycle.
  - halt_req=1 -> HALTED.
  - Otherwise -> FETCH with step=0.
- Step counter rules:
  - step <= step+1 on every advancing transition.
  - step holds during wait cycles.
  - step <= 0 on entry to FETCH, IDLE or HALTED.
  - step never exceeds 4.
  - wait_cnt clears on every state change.
- HALTED: done=1, step=0, all strobes 0, flags held.
  - start=1 -> FETCH; clears flags. PC is not reset here; restart continues from the current PC.
- Simultaneous events:
  - mem_ready on the same cycle wait_cnt reaches WAIT_MAX: mem_ready wins, no timeout.
  - start while busy is ignored.
  - halt_req mid-instruction is honoured only at END.
- Reset asserted mid-MEM: immediate return to IDLE. mem_req drops asynchronously and the memory transaction is abandoned.
- Instruction latency with zero-wait memory:
  - NOP: 2 cycles.
  - JMP: 3 cycles.
  - ALU: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.

Decomposition:
- Shared package mc_pkg:
  - State enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED).
  - Opcode constants (OP_NOP, OP_LOAD, OP_STORE, OP_JMP, OP_HALT) and class-decode function is_alu/is_illegal.
  - Step code constants T_FETCH=0 … T_WB_LD=4.
- One sub-module: mc_wait_timer, containing wait_cnt, the clear and increment controls, and the expired output compared against WAIT_MAX. Everything else stays in one FSM.

Test Plan:
- Reset, start=1, opcode=0011, mem_ready=1 always -> step sequence 0,1,2,3,0. ir_load@c1, pc_inc@c2, alu_go@c3, reg_we@c4. Next FETCH at c5 with busy=1 throughout.
- LOAD (1000) with mem_ready low 2 cycles in MEM -> step holds at 3 for 3 cycles, then reg_we at step 4. Total 7 cycles; mem_we=0 throughout.
- STORE (1001), zero wait -> mem_req=mem_we=1 at step 3, no reg_we, 4 cycles. Then halt_req=1 at END -> HALTED, done=1, step=0.
- Opcode 1100 -> DECODE then HALTED with illegal=1, no alu_go. start=1 -> illegal=0, FETCH.
- WAIT_MAX=3, mem_ready held 0 in FETCH -> timeout=1 and HALTED after 3 wait cycles. Also mem_ready=1 exactly on the 3rd wait cycle -> no timeout, DECODE.
- rst_n low during MEM wait -> same-cycle mem_req=0, step=0, busy=0, flags 0. Restart is normal.
